// File: rtl/des_ks_pkg.sv
// DES key schedule shared definitions: PC1/PC2 tables, shift schedule,
// C/D rotation helpers and the sequencer state type.
package des_ks_pkg;

   // PC1: DES key bit numbers (1 = key MSB) feeding C (first 28) and D.
   localparam int unsigned PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   // PC2: C/D bit numbers (1 = C MSB) selected for each round-key bit.
   localparam int unsigned PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   // Per-round shift (index 0 unused) and cumulative shift S(r).
   localparam int unsigned SHIFT_T [17] = '{
      0, 1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
   };
   localparam int unsigned S_CUM [17] = '{
      0, 1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28
   };

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ks_state_e;

   function automatic logic [55:0] pc1(input logic [63:0] key);
      logic [55:0] cd;
      cd = '0;
      for (int i = 0; i < 56; i++) begin
         cd[55-i] = key[64-PC1_T[i]];
      end
      return cd;
   endfunction

   // Out-of-range round numbers rotate by zero.
   function automatic int unsigned shift_of(input int r);
      return (r >= 1 && r <= 16) ? SHIFT_T[r] : 0;
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] val,
                                          input int unsigned n);
      logic [55:0] t;
      t = {val, val} >> (28 - n);
      return t[27:0];
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] val,
                                          input int unsigned n);
      logic [55:0] t;
      t = {val, val} >> n;
      return t[27:0];
   endfunction

endpackage

// File: rtl/des_pc2_perm.sv
// Combinational PC2 permutation: 56-bit C/D register to 48-bit round key.
// Ports: cd_i (C in [55:28], D in [27:0]), rk_o (bit 47 = PC2 output bit 1).
module des_pc2_perm
   import des_ks_pkg::*;
(
   input  logic [55:0] cd_i,
   output logic [47:0] rk_o
);

   always_comb begin
      rk_o = '0;
      for (int j = 0; j < 48; j++) begin
         rk_o[47-j] = cd_i[56-PC2_T[j]];
      end
   end

endmodule

// File: rtl/des_key_sched_seq.sv
// Sequential DES key schedule: one key in, ROUNDS round keys streamed out.
// Ports: CLK/RST, key_in/mode/key_valid/key_ready (job start),
// rk/rk_round/rk_last/rk_valid/rk_ready (round-key stream).
module des_key_sched_seq
   import des_ks_pkg::*;
#(
   parameter int ROUNDS = 16,
   parameter int RIDX_W = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [63:0]       key_in,
   input  logic              mode,
   input  logic              key_valid,
   output logic              key_ready,
   output logic [47:0]       rk,
   output logic [RIDX_W-1:0] rk_round,
   output logic              rk_last,
   output logic              rk_valid,
   input  logic              rk_ready
);

   if (ROUNDS < 1 || ROUNDS > 16) begin : g_bad_rounds
      $error("des_key_sched_seq: ROUNDS must be in 1..16");
   end
   if ((64'd1 << RIDX_W) < 64'(ROUNDS)) begin : g_bad_ridx
      $error("des_key_sched_seq: RIDX_W too narrow for ROUNDS");
   end

   // Decrypt starts at the last key: total rotation S(ROUNDS) mod 28.
   localparam int unsigned DEC_ROT = S_CUM[ROUNDS] % 28;
   localparam logic [RIDX_W-1:0] LAST_CNT = RIDX_W'(ROUNDS - 1);

   ks_state_e         state_q, state_d;
   logic [55:0]       cd_q, cd_d;
   logic [RIDX_W-1:0] cnt_q, cnt_d;
   logic              mode_q, mode_d;
   logic [55:0]       pc1_key;
   logic [47:0]       pc2_out;

   assign pc1_key = pc1(key_in);

   des_pc2_perm u_pc2 (
      .cd_i (cd_q),
      .rk_o (pc2_out)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         cd_q    <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cd_q    <= cd_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cd_d    = cd_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      case (state_q)
         IDLE: begin
            if (key_valid) begin
               mode_d  = mode;
               cnt_d   = '0;
               state_d = RUN;
               if (mode) begin
                  cd_d = {rotl28(pc1_key[55:28], DEC_ROT),
                          rotl28(pc1_key[27:0], DEC_ROT)};
               end else begin
                  cd_d = {rotl28(pc1_key[55:28], SHIFT_T[1]),
                          rotl28(pc1_key[27:0], SHIFT_T[1])};
               end
            end
         end
         RUN: begin
            if (rk_ready) begin
               if (cnt_q == LAST_CNT) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  // Decrypt undoes the shift of the round just emitted;
                  // encrypt applies the shift of the round to come.
                  if (mode_q) begin
                     cd_d = {rotr28(cd_q[55:28], shift_of(ROUNDS - int'(cnt_q))),
                             rotr28(cd_q[27:0], shift_of(ROUNDS - int'(cnt_q)))};
                  end else begin
                     cd_d = {rotl28(cd_q[55:28], shift_of(int'(cnt_q) + 2)),
                             rotl28(cd_q[27:0], shift_of(int'(cnt_q) + 2))};
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      key_ready = (state_q == IDLE);
      rk_valid  = (state_q == RUN);
      rk        = '0;
      rk_round  = '0;
      rk_last   = 1'b0;
      if (state_q == RUN) begin
         rk       = pc2_out;
         rk_last  = (cnt_q == LAST_CNT);
         rk_round = mode_q ? (LAST_CNT - cnt_q) : cnt_q;
      end
   end

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Self-checking bench for des_key_sched_seq (ROUNDS=16 and ROUNDS=4 builds)
// against an absolute-rotation DES key schedule model.
module tb_des_key_sched_seq;

   localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

   logic        CLK = 1'b0;
   logic        RST;
   logic [63:0] key_in;
   logic        mode, key_valid, rk_ready;
   logic        key_ready, rk_last, rk_valid;
   logic [47:0] rk;
   logic [3:0]  rk_round;

   logic [63:0] key_in4;
   logic        mode4, key_valid4, rk_ready4;
   logic        key_ready4, rk_last4, rk_valid4;
   logic [47:0] rk4;
   logic [1:0]  rk_round4;

   int vecs = 0;
   int errs = 0;

   logic [47:0] got_rk[$];
   int          got_rnd[$];
   logic        got_last[$];
   logic [47:0] enc_q[$];
   int          stall_bad;
   bit          timed_out;
   logic        first_valid;
   logic        ready_after;

   int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   int SH [17] = '{0, 1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   des_key_sched_seq #(.ROUNDS(16), .RIDX_W(4)) dut (
      .CLK(CLK), .RST(RST), .key_in(key_in), .mode(mode),
      .key_valid(key_valid), .key_ready(key_ready), .rk(rk),
      .rk_round(rk_round), .rk_last(rk_last), .rk_valid(rk_valid),
      .rk_ready(rk_ready)
   );

   des_key_sched_seq #(.ROUNDS(4), .RIDX_W(2)) dut4 (
      .CLK(CLK), .RST(RST), .key_in(key_in4), .mode(mode4),
      .key_valid(key_valid4), .key_ready(key_ready4), .rk(rk4),
      .rk_round(rk_round4), .rk_last(rk_last4), .rk_valid(rk_valid4),
      .rk_ready(rk_ready4)
   );

   always #5 CLK = ~CLK;

   // Round key r computed from scratch: total rotation S(r) applied to PC1.
   function automatic logic [47:0] ref_rk(input logic [63:0] k, input int r);
      logic [27:0] c, d;
      logic [55:0] cd;
      logic [47:0] o;
      int s;
      for (int i = 0; i < 28; i++) begin
         c[27-i] = k[64-PC1[i]];
         d[27-i] = k[64-PC1[28+i]];
      end
      s = 0;
      for (int j = 1; j <= r; j++) s += SH[j];
      s = s % 28;
      c = 28'((c << s) | (c >> (28 - s)));
      d = 28'((d << s) | (d >> (28 - s)));
      cd = {c, d};
      for (int j = 0; j < 48; j++) o[47-j] = cd[56-PC2[j]];
      return o;
   endfunction

   function automatic logic [47:0] rk_at(input int i);
      if (i < got_rk.size()) return got_rk[i];
      return 'x;
   endfunction

   function automatic int rnd_at(input int i);
      if (i < got_rnd.size()) return got_rnd[i];
      return -1;
   endfunction

   function automatic logic last_at(input int i);
      if (i < got_last.size()) return got_last[i];
      return 1'bx;
   endfunction

   task automatic do_job(input logic [63:0] k, input logic m, input int pct,
                         input int hold_at, input int hold_len, input bit poke);
      logic [47:0] prk;
      logic [3:0]  prnd;
      logic        pl;
      bit          stalled, done;
      int          cyc, held;
      got_rk.delete();
      got_rnd.delete();
      got_last.delete();
      stall_bad = 0;
      held = 0;
      cyc = 0;
      while (key_ready !== 1'b1 && cyc < 50) begin
         @(negedge CLK);
         cyc++;
      end
      key_in = k;
      mode = m;
      key_valid = 1'b1;
      rk_ready = 1'b0;
      @(negedge CLK);
      key_valid = 1'b0;
      mode = ~m;
      key_in = {$urandom, $urandom};
      first_valid = rk_valid;
      stalled = 0;
      done = 0;
      cyc = 0;
      prk = '0;
      prnd = '0;
      pl = 1'b0;
      while (!done && cyc < 400) begin
         if (stalled && (rk !== prk || rk_round !== prnd ||
                         rk_last !== pl || rk_valid !== 1'b1))
            stall_bad++;
         key_valid = poke && (cyc == 3);
         if (got_rk.size() == hold_at && held < hold_len) begin
            rk_ready = 1'b0;
            held++;
         end else begin
            rk_ready = ($urandom_range(0, 99) >= pct);
         end
         if (rk_valid === 1'b1 && rk_ready) begin
            got_rk.push_back(rk);
            got_rnd.push_back(int'(rk_round));
            got_last.push_back(rk_last);
            done = (rk_last === 1'b1);
         end
         stalled = (rk_valid === 1'b1) && !rk_ready;
         prk = rk;
         prnd = rk_round;
         pl = rk_last;
         @(negedge CLK);
         cyc++;
      end
      key_valid = 1'b0;
      rk_ready = 1'b0;
      timed_out = !done;
      ready_after = key_ready;
   endtask

   task automatic test_reset();
      @(negedge CLK);
      vecs++;
      if (key_ready !== 1'b1) begin
         errs++; $display("FAIL rst_key_ready: got %b want 1", key_ready);
      end
      vecs++;
      if (rk_valid !== 1'b0) begin
         errs++; $display("FAIL rst_rk_valid: got %b want 0", rk_valid);
      end
      vecs++;
      if (rk !== 48'h0) begin
         errs++; $display("FAIL rst_rk: got %h want 0", rk);
      end
      vecs++;
      if (rk_round !== 4'h0 || rk_last !== 1'b0) begin
         errs++; $display("FAIL rst_round_last: got %h/%b want 0/0", rk_round, rk_last);
      end
      RST = 1'b0;
      @(negedge CLK);
      vecs++;
      if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
         errs++; $display("FAIL rst_release: got ready=%b valid=%b want 1/0", key_ready, rk_valid);
      end
   endtask

   task automatic test_encrypt();
      do_job(KEY, 1'b0, 0, -1, 0, 1'b0);
      vecs++;
      if (timed_out || got_rk.size() != 16) begin
         errs++; $display("FAIL enc_count: got %0d want 16", got_rk.size());
      end
      vecs++;
      if (first_valid !== 1'b1) begin
         errs++; $display("FAIL enc_latency: got rk_valid=%b want 1", first_valid);
      end
      vecs++;
      if (rk_at(0) !== 48'h1B02EFFC7072 || rnd_at(0) != 0) begin
         errs++; $display("FAIL enc_k1: got %h r%0d want 1b02effc7072 r0", rk_at(0), rnd_at(0));
      end
      vecs++;
      if (rk_at(1) !== 48'h79AED9DBC9E5) begin
         errs++; $display("FAIL enc_k2: got %h want 79aed9dbc9e5", rk_at(1));
      end
      vecs++;
      if (rk_at(15) !== 48'hCB3D8B0E17F5 || last_at(15) !== 1'b1) begin
         errs++; $display("FAIL enc_k16: got %h last=%b want cb3d8b0e17f5 1", rk_at(15), last_at(15));
      end
      vecs++;
      if (ready_after !== 1'b1) begin
         errs++; $display("FAIL enc_ready_after: got %b want 1", ready_after);
      end
      for (int i = 0; i < 16; i++) begin
         vecs++;
         if (rk_at(i) !== ref_rk(KEY, i + 1) || rnd_at(i) != i ||
             last_at(i) !== (i == 15)) begin
            errs++;
            $display("FAIL enc_seq[%0d]: got %h r%0d l%b want %h r%0d l%b", i,
                     rk_at(i), rnd_at(i), last_at(i), ref_rk(KEY, i + 1), i, i == 15);
         end
      end
      enc_q = got_rk;
   endtask

   task automatic test_decrypt();
      do_job(KEY, 1'b1, 0, -1, 0, 1'b0);
      vecs++;
      if (timed_out || got_rk.size() != 16) begin
         errs++; $display("FAIL dec_count: got %0d want 16", got_rk.size());
      end
      vecs++;
      if (rk_at(0) !== 48'hCB3D8B0E17F5 || rnd_at(0) != 15) begin
         errs++; $display("FAIL dec_first: got %h r%0d want cb3d8b0e17f5 r15", rk_at(0), rnd_at(0));
      end
      vecs++;
      if (rk_at(15) !== 48'h1B02EFFC7072 || rnd_at(15) != 0 || last_at(15) !== 1'b1) begin
         errs++; $display("FAIL dec_last: got %h r%0d l%b want 1b02effc7072 r0 l1", rk_at(15), rnd_at(15), last_at(15));
      end
      for (int i = 0; i < 16; i++) begin
         vecs++;
         if (enc_q.size() != 16 || rk_at(i) !== enc_q[15 - i] ||
             rnd_at(i) != 15 - i || last_at(i) !== (i == 15)) begin
            errs++;
            $display("FAIL dec_reverse[%0d]: got %h r%0d want %h r%0d", i,
                     rk_at(i), rnd_at(i), ref_rk(KEY, 16 - i), 15 - i);
         end
      end
   endtask

   task automatic test_backpressure();
      do_job(KEY, 1'b0, 0, 2, 5, 1'b0);
      vecs++;
      if (stall_bad != 0) begin
         errs++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stall_bad);
      end
      vecs++;
      if (timed_out || got_rk.size() != 16) begin
         errs++; $display("FAIL bp_count: got %0d want 16", got_rk.size());
      end
      for (int i = 0; i < 16; i++) begin
         vecs++;
         if (rk_at(i) !== ref_rk(KEY, i + 1) || rnd_at(i) != i) begin
            errs++; $display("FAIL bp_seq[%0d]: got %h r%0d want %h r%0d", i, rk_at(i), rnd_at(i), ref_rk(KEY, i + 1), i);
         end
      end
   endtask

   task automatic test_random();
      logic [63:0] k;
      logic        m;
      int          r;
      for (int n = 0; n < 6; n++) begin
         k = {$urandom, $urandom};
         m = n[0];
         do_job(k, m, 35, -1, 0, 1'b0);
         vecs++;
         if (timed_out || got_rk.size() != 16 || stall_bad != 0) begin
            errs++; $display("FAIL rnd%0d_job: got n=%0d stall=%0d want 16/0", n, got_rk.size(), stall_bad);
         end
         for (int i = 0; i < 16; i++) begin
            r = m ? 16 - i : i + 1;
            vecs++;
            if (rk_at(i) !== ref_rk(k, r) || rnd_at(i) != r - 1 ||
                last_at(i) !== (i == 15)) begin
               errs++;
               $display("FAIL rnd%0d[%0d]: got %h r%0d l%b want %h r%0d", n, i,
                        rk_at(i), rnd_at(i), last_at(i), ref_rk(k, r), r - 1);
            end
         end
      end
   endtask

   task automatic test_ignored_start();
      logic [63:0] k;
      k = {$urandom, $urandom};
      do_job(k, 1'b0, 20, -1, 0, 1'b1);
      vecs++;
      if (timed_out || got_rk.size() != 16) begin
         errs++; $display("FAIL ign_count: got %0d want 16", got_rk.size());
      end
      for (int i = 0; i < 16; i++) begin
         vecs++;
         if (rk_at(i) !== ref_rk(k, i + 1)) begin
            errs++; $display("FAIL ign_seq[%0d]: got %h want %h", i, rk_at(i), ref_rk(k, i + 1));
         end
      end
   endtask

   task automatic test_async_reset();
      int cyc;
      key_in = KEY;
      mode = 1'b0;
      key_valid = 1'b1;
      rk_ready = 1'b1;
      @(negedge CLK);
      key_valid = 1'b0;
      cyc = 0;
      while (!(rk_valid === 1'b1 && rk_round === 4'd7) && cyc < 50) begin
         @(negedge CLK);
         cyc++;
      end
      vecs++;
      if (cyc >= 50) begin
         errs++; $display("FAIL ar_reach_r8: got timeout want round 8");
      end
      #2 RST = 1'b1;
      #1;
      vecs++;
      if (key_ready !== 1'b1 || rk_valid !== 1'b0 || rk !== 48'h0 ||
          rk_round !== 4'h0 || rk_last !== 1'b0) begin
         errs++;
         $display("FAIL ar_immediate: got rdy=%b v=%b rk=%h r=%h l=%b want 1 0 0 0 0",
                  key_ready, rk_valid, rk, rk_round, rk_last);
      end
      @(negedge CLK);
      RST = 1'b0;
      rk_ready = 1'b0;
      @(negedge CLK);
      vecs++;
      if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
         errs++; $display("FAIL ar_release: got rdy=%b v=%b want 1 0", key_ready, rk_valid);
      end
      do_job(64'h0, 1'b0, 0, -1, 0, 1'b0);
      vecs++;
      if (timed_out || got_rk.size() != 16 || rk_at(0) !== 48'h0 || rnd_at(0) != 0) begin
         errs++; $display("FAIL ar_restart: got n=%0d rk=%h r%0d want 16 0 r0", got_rk.size(), rk_at(0), rnd_at(0));
      end
   endtask

   task automatic test_rounds4();
      logic [63:0] keys [2];
      logic [47:0] g_rk [$];
      int          g_r [$];
      logic        g_l [$];
      int          cyc;
      keys[0] = KEY;
      keys[1] = {$urandom, $urandom};
      for (int n = 0; n < 2; n++) begin
         g_rk.delete(); g_r.delete(); g_l.delete();
         key_in4 = keys[n];
         mode4 = 1'b1;
         key_valid4 = 1'b1;
         rk_ready4 = 1'b0;
         @(negedge CLK);
         key_valid4 = 1'b0;
         cyc = 0;
         while (g_rk.size() < 4 && cyc < 100) begin
            rk_ready4 = $urandom_range(0, 3) != 0;
            if (rk_valid4 === 1'b1 && rk_ready4) begin
               g_rk.push_back(rk4);
               g_r.push_back(int'(rk_round4));
               g_l.push_back(rk_last4);
            end
            @(negedge CLK);
            cyc++;
         end
         rk_ready4 = 1'b0;
         vecs++;
         if (g_rk.size() != 4 || key_ready4 !== 1'b1) begin
            errs++; $display("FAIL r4_job%0d: got n=%0d rdy=%b want 4 1", n, g_rk.size(), key_ready4);
         end
         for (int i = 0; i < g_rk.size(); i++) begin
            vecs++;
            if (g_rk[i] !== ref_rk(keys[n], 4 - i) || g_r[i] != 3 - i ||
                g_l[i] !== (i == 3)) begin
               errs++;
               $display("FAIL r4_%0d[%0d]: got %h r%0d l%b want %h r%0d l%b", n, i,
                        g_rk[i], g_r[i], g_l[i], ref_rk(keys[n], 4 - i), 3 - i, i == 3);
            end
         end
      end
   endtask

   initial begin
      RST = 1'b1;
      key_in = '0; mode = 1'b0; key_valid = 1'b0; rk_ready = 1'b0;
      key_in4 = '0; mode4 = 1'b0; key_valid4 = 1'b0; rk_ready4 = 1'b0;
      test_reset();
      test_encrypt();
      test_decrypt();
      test_backpressure();
      test_random();
      test_ignored_start();
      test_async_reset();
      test_rounds4();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/des_key_sched_seq.md
Name: des_key_sched_seq

Overview:
- Sequential, parametrised DES key schedule. Accepts one 64-bit key per job and streams ROUNDS 48-bit round keys, one per handshake.
- Supports encrypt order (K1..Kn, left rotations) and decrypt order (Kn..K1, right rotations). Only one 56-bit C/D register is held, instead of 16 unrolled stages.
- Sits between the key register and the DES round datapath, which consumes one round key per round.

Parameters:
- ROUNDS, 16: number of round keys emitted per job. Legal range 1..16; values outside this range are a compile-time error.
- RIDX_W, 4: width of the round-index output. Must satisfy 2^RIDX_W >= ROUNDS.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- key_in  in  64  DES key. KEY[63] is DES bit 1. Parity bits are ignored by PC1.
- mode  in  1  0 = encrypt order, 1 = decrypt order. Sampled with key_in.
- key_valid  in  1  request to start a job.
- key_ready  out  1  block is IDLE and accepts a key.
- rk  out  48  current round key. rk[47] is PC2 output bit 1.
- rk_round  out  RIDX_W  round number of rk. Encrypt counts 1..ROUNDS; decrypt counts ROUNDS..1. Stored as value-1.
- rk_last  out  1  rk is the final key of the job.
- rk_valid  out  1  rk, rk_round and rk_last are valid.
- rk_ready  in  1  consumer accepts rk this cycle.

Behaviour:
- Reset values: state = IDLE, key_ready = 1, rk_valid = 0, rk_last = 0, rk = 0, rk_round = 0, C/D = 0, counter = 0.
- Reset mid-job aborts the job immediately. No partial key is emitted after RST deasserts.
- Shift table SHIFT[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Cumulative S(r) = sum of SHIFT[1..r]; S(16) = 28.
- States: IDLE, RUN.
- IDLE:
  - key_ready = 1.
  - On key_valid & key_ready:
    - encrypt: C/D <= rotl(PC1(key_in), SHIFT[1]).
    - decrypt: C/D <= rotl(PC1(key_in), S(ROUNDS) mod 28). This is a constant per halve from the package.
  - Latch mode, counter <= 0, go to RUN.
- RUN:
  - key_ready = 0, rk_valid = 1, rk = PC2(C/D) combinationally from the register.
  - rk_round: encrypt = counter+1; decrypt = ROUNDS-counter.
  - rk_last = (counter == ROUNDS-1).
- Latency: key accepted at edge N; first rk_valid is high in the cycle after edge N. There are no bubbles while rk_ready = 1, so one job takes ROUNDS+1 cycles including the accept cycle.
- On rk_valid & rk_ready and not last:
  - counter++.
  - encrypt: C/D <= rotl(C/D, SHIFT[counter+2]).
  - decrypt: C/D <= rotr(C/D, SHIFT[ROUNDS-counter]).
  - C and D rotate independently, 28 bits each, with wrap-around.
- On rk_valid & rk_ready & rk_last: go to IDLE. key_ready is high in the next cycle. A new key is not accepted in the same cycle as the last transfer.
- rk_ready = 0 while rk_valid = 1: rk, rk_round and rk_last stay stable, and C/D and the counter hold. rk_valid never drops before the transfer completes.
- key_valid while in RUN is ignored; key_ready = 0 in that state.
- mode changes during RUN have no effect.
- Equivalence: decrypt with ROUNDS = 16 emits exactly the encrypt sequence reversed.

Decomposition:
- Package des_ks_pkg holds:
  - PC1 table (56 entries) and PC2 table (48 entries) as localparam arrays.
  - SHIFT[1..16] and the cumulative S[0..16].
  - Functions: pc1(), rotl28(val, n), rotr28(val, n).
  - State enum {IDLE, RUN}.
- One natural sub-module, des_pc2_perm: combinational 56→48 PC2 permutation driven by the C/D register. It is reusable by other key-schedule variants.

Test Plan:
- Encrypt, ROUNDS = 16, key_in = 64'h133457799BBCDFF1, rk_ready = 1:
  - rk_valid high in the cycle after accept.
  - rk = 48'h1B02EFFC7072 (round 1), then 48'h79AED9DBC9E5 (round 2).
  - Round 16 rk = 48'hCB3D8B0E17F5 with rk_last = 1.
  - key_ready = 1 in the following cycle.
- Decrypt, same key:
  - First rk = 48'hCB3D8B0E17F5 with rk_round = 16.
  - Second rk = encrypt round-15 key.
  - Last rk = 48'h1B02EFFC7072 with rk_round = 1 and rk_last = 1.
  - Full sequence equals the encrypt sequence reversed.
- Backpressure:
  - Hold rk_ready = 0 for 5 cycles at round 3; rk and rk_round stay constant.
  - After release the sequence continues with no skip or duplicate, and the job totals 16 transfers.
- Async reset: assert RST at round 8 between clock edges.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release key_ready = 1. A new job with key 64'h0 restarts at round 1 and rk = 48'h0.
- Ignored start: pulse key_valid with a different key during RUN; the output stream matches the original key.
- ROUNDS = 4 build, decrypt:
  - Emits encrypt keys 4, 3, 2, 1 of key 64'h133457799BBCDFF1.
  - rk_last is set on rk_round = 1.
